// File: rtl/ysyx_23060278_pkg.sv
// Shared decode definitions for the IDU and EXU.
// Contents:
//   Op*             7-bit RV32I/RV64I major opcodes.
//   fmt_e           immediate/operand format, as presented on the IDU's out_fmt.
//   is_rv64_only()  true for the OP-IMM-32 / OP-32 word-op opcodes.
package ysyx_23060278_pkg;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpOp32    = 7'b0111011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  typedef enum logic [2:0] {
    FmtR    = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtNone = 3'd7
  } fmt_e;

  function automatic logic is_rv64_only(input logic [6:0] opcode);
    return (opcode == OpOpImm32) || (opcode == OpOp32);
  endfunction

endpackage

// File: rtl/ysyx_23060278_imm_gen.sv
// Combinational format classification and immediate extraction.
// Ports:
//   inst_i     raw 32-bit instruction word
//   imm_o      immediate, sign-extended from inst[31] to XLEN (0 for R and illegal)
//   fmt_o      operand format (FmtNone when illegal)
//   illegal_o  encoding not supported by this configuration
module ysyx_23060278_imm_gen
  import ysyx_23060278_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          RV64_OPS = (XLEN == 64)
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [31:0] imm32;

  assign opcode = inst_i[6:0];

  always_comb begin
    fmt_o     = FmtNone;
    illegal_o = 1'b0;
    case (opcode)
      OpJalr, OpLoad, OpOpImm, OpMiscMem, OpSystem: fmt_o = FmtI;
      OpStore:                                      fmt_o = FmtS;
      OpBranch:                                     fmt_o = FmtB;
      OpLui, OpAuipc:                               fmt_o = FmtU;
      OpJal:                                        fmt_o = FmtJ;
      OpOp:                                         fmt_o = FmtR;
      OpOpImm32:                                    fmt_o = FmtI;
      OpOp32:                                       fmt_o = FmtR;
      default:                                      illegal_o = 1'b1;
    endcase
    // Every listed opcode ends in 2'b11, but keep the compressed-space test explicit.
    if (inst_i[1:0] != 2'b11) illegal_o = 1'b1;
    if (is_rv64_only(opcode) && !RV64_OPS) illegal_o = 1'b1;
    if (illegal_o) fmt_o = FmtNone;
  end

  always_comb begin
    imm32 = 32'd0;
    case (fmt_o)
      FmtI:    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      FmtS:    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FmtB:    imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      FmtU:    imm32 = {inst_i[31:12], 12'b0};
      FmtJ:    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  // Widen to XLEN: fill with the sign, then drop the 32-bit value into the low half.
  always_comb begin
    imm_o       = {XLEN{imm32[31]}};
    imm_o[31:0] = imm32;
  end

endmodule

// File: rtl/ysyx_23060278_idu_stage.sv
// Instruction decode stage: combinational decode of in_inst, registered into a
// single-entry valid/ready output slot (1-cycle latency, full throughput).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop the held bundle and refuse the incoming one
//   in_valid/in_ready   upstream handshake, in_inst/in_pc payload
//   out_valid/out_ready downstream handshake
//   out_pc, out_opcode, out_func3, out_func7, out_rs1, out_rs2, out_rd
//                       raw fields of the held instruction
//   out_imm, out_fmt, out_illegal
//                       decoded immediate, format and legality
module ysyx_23060278_idu_stage
  import ysyx_23060278_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          RV64_OPS = (XLEN == 64)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  if (!(XLEN == 32 || XLEN == 64)) begin : gen_xlen_check
    $error("ysyx_23060278_idu_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  ysyx_23060278_imm_gen #(
    .XLEN     (XLEN),
    .RV64_OPS (RV64_OPS)
  ) u_imm_gen (
    .inst_i    (in_inst),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  logic            valid_q, valid_d;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  fmt_e            fmt_q;
  logic            illegal_q;
  logic            accept;

  // in_ready already excludes flush, so a flush cycle can never accept.
  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      inst_q    <= 32'd0;
      pc_q      <= '0;
      imm_q     <= '0;
      fmt_q     <= FmtR;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        inst_q    <= in_inst;
        pc_q      <= in_pc;
        imm_q     <= dec_imm;
        fmt_q     <= dec_fmt;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_opcode  = inst_q[6:0];
  assign out_func3   = inst_q[14:12];
  assign out_func7   = inst_q[31:25];
  assign out_rs1     = inst_q[19:15];
  assign out_rs2     = inst_q[24:20];
  assign out_rd      = inst_q[11:7];
  assign out_imm     = imm_q;
  assign out_fmt     = fmt_q;
  assign out_illegal = illegal_q;

endmodule
